// File: rtl/acia_pkg.sv
// Shared constants, state encoding and status-byte helper for the ACIA transmit slave.
package acia_pkg;

    localparam logic [15:0] ACIA_BASE   = 16'h8000;

    localparam logic [1:0]  ACIA_DATA   = 2'd0;
    localparam logic [1:0]  ACIA_STATUS = 2'd1;
    localparam logic [1:0]  ACIA_CMD    = 2'd2;
    localparam logic [1:0]  ACIA_CTRL   = 2'd3;

    localparam int unsigned ST_OVR      = 2;
    localparam int unsigned ST_TDRE     = 4;
    localparam int unsigned ST_IDLE     = 5;

    localparam int unsigned BAUD_CNT_W  = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [7:0] acia_status(input logic tdre, input logic idle, input logic ovr);
        logic [7:0] s;
        s          = '0;
        s[ST_TDRE] = tdre;
        s[ST_IDLE] = idle;
        s[ST_OVR]  = ovr;
        return s;
    endfunction

endpackage

// File: rtl/acia_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only if a pop occurs in the same cycle.
module acia_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/acia_tx.sv
// 6551-style ACIA transmit slave: CPU-visible register file, TX FIFO and 8N1 serialiser.
module acia_tx
    import acia_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 87,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       rwb,
    input  logic       strobe,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       txd,
    output logic       tx_busy
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);

    tx_state_e             state;
    logic [BAUD_CNT_W-1:0] baud_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [7:0]            cmd_q;
    logic [7:0]            ctrl_q;
    logic                  ovr_q;

    logic       bus_wr_c;
    logic       bus_rd_c;
    logic       push_c;
    logic       flush_c;
    logic       status_rd_c;
    logic       pop_c;
    logic       bit_end_c;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    assign bus_wr_c    = cs & strobe & ~rwb;
    assign bus_rd_c    = cs & strobe & rwb;
    assign push_c      = bus_wr_c && (addr == ACIA_DATA);
    assign flush_c     = bus_wr_c && (addr == ACIA_STATUS);
    assign status_rd_c = bus_rd_c && (addr == ACIA_STATUS);
    assign bit_end_c   = (baud_cnt == BAUD_LAST);

    // Serialiser takes the next byte when idle or at the end of a stop bit.
    assign pop_c = ~fifo_empty & ~flush_c &
                   ((state == TX_IDLE) | ((state == TX_STOP) & bit_end_c));

    assign tx_busy = ~fifo_empty | (state != TX_IDLE);

    acia_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        data_out = 8'h00;
        if (cs) begin
            case (addr)
                ACIA_DATA:   data_out = 8'h00;
                ACIA_STATUS: data_out = acia_status(~fifo_full, ~tx_busy, ovr_q);
                ACIA_CMD:    data_out = cmd_q;
                ACIA_CTRL:   data_out = ctrl_q;
                default:     data_out = 8'h00;
            endcase
        end
    end

    // Command/control are plain storage and survive a programmed reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q  <= 8'h00;
            ctrl_q <= 8'h00;
        end else if (bus_wr_c) begin
            if (addr == ACIA_CMD)  cmd_q  <= data_in;
            if (addr == ACIA_CTRL) ctrl_q <= data_in;
        end
    end

    // An overflow in the same cycle as a status read wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else if (flush_c) begin
            ovr_q <= 1'b0;
        end else if (push_c && fifo_full && !pop_c) begin
            ovr_q <= 1'b1;
        end else if (status_rd_c) begin
            ovr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TX_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (flush_c) begin
            state    <= TX_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop_c) begin
                        shreg    <= fifo_dout;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        txd      <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        txd      <= shreg[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end_c) begin
                        baud_cnt <= '0;
                        if (pop_c) begin
                            shreg   <= fifo_dout;
                            bit_cnt <= '0;
                            txd     <= 1'b0;
                            state   <= TX_START;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acia_tx.sv
// Bench for acia_tx: register vectors, hand-written frame/overflow/reset sequences and a random run against a frame-level model.
module tb_acia_tx;

    localparam int unsigned BD    = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic [1:0] addr;
    logic       rwb;
    logic       strobe;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       txd;
    logic       tx_busy;

    always #5 clk = ~clk;

    acia_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .addr     (addr),
        .rwb      (rwb),
        .strobe   (strobe),
        .data_in  (data_in),
        .data_out (data_out),
        .txd      (txd),
        .tx_busy  (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: bytes waiting, the byte on the wire and the edge its frame began.
    int         t;
    int         fstart;
    bit         active;
    bit         m_ovr;
    logic [7:0] cur;
    logic [7:0] pend[$];
    logic [7:0] m_cmd;
    logic [7:0] m_ctrl;

    typedef struct {
        logic       c;
        logic [1:0] a;
        logic       r;
        logic [7:0] d;
        logic       chk_rd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[11] = '{
        '{1'b1, 2'd1, 1'b1, 8'h00, 1'b1, 8'h30},
        '{1'b1, 2'd0, 1'b1, 8'h00, 1'b1, 8'h00},
        '{1'b1, 2'd2, 1'b0, 8'hA5, 1'b0, 8'h00},
        '{1'b1, 2'd3, 1'b0, 8'h3C, 1'b0, 8'h00},
        '{1'b1, 2'd2, 1'b1, 8'h00, 1'b1, 8'hA5},
        '{1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 8'h3C},
        '{1'b0, 2'd2, 1'b1, 8'h00, 1'b1, 8'h00},
        '{1'b1, 2'd1, 1'b0, 8'hFF, 1'b0, 8'h00},
        '{1'b1, 2'd2, 1'b1, 8'h00, 1'b1, 8'hA5},
        '{1'b1, 2'd3, 1'b1, 8'h00, 1'b1, 8'h3C},
        '{1'b1, 2'd1, 1'b1, 8'h00, 1'b1, 8'h30}
    };

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        active = 1'b0;
        m_ovr  = 1'b0;
        m_cmd  = 8'h00;
        m_ctrl = 8'h00;
        t      = 0;
        fstart = 0;
        cur    = 8'h00;
    endtask

    function automatic logic m_busy();
        return active || (pend.size() > 0);
    endfunction

    function automatic logic m_txd();
        int b;
        if (!active) return 1'b1;
        b = (t - fstart) / BD;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_read(input logic c, input logic [1:0] a);
        logic [7:0] s;
        s = 8'h00;
        if (!c) return 8'h00;
        case (a)
            2'd1: begin
                s[5] = !m_busy();
                s[4] = (pend.size() != DEPTH);
                s[2] = m_ovr;
            end
            2'd2: s = m_cmd;
            2'd3: s = m_ctrl;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    task automatic model_edge(input logic c, input logic [1:0] a, input logic r, input logic s, input logic [7:0] d);
        bit wr, rd, popped, full_before, ovr_set;
        wr      = c && s && !r;
        rd      = c && s && r;
        popped  = 1'b0;
        ovr_set = 1'b0;
        t++;
        if (wr && a == 2'd1) begin
            pend.delete();
            active = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (active && (t - fstart == 10 * BD)) active = 1'b0;
            full_before = (pend.size() == DEPTH);
            if (!active && pend.size() > 0) begin
                cur    = pend.pop_front();
                fstart = t;
                active = 1'b1;
                popped = 1'b1;
            end
            if (wr && a == 2'd0) begin
                if (!full_before || popped) pend.push_back(d);
                else ovr_set = 1'b1;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (rd && a == 2'd1) m_ovr = 1'b0;
            if (wr && a == 2'd2) m_cmd = d;
            if (wr && a == 2'd3) m_ctrl = d;
        end
    endtask

    // One bus cycle: drive, sample data_out at the negedge, clock, then check txd/tx_busy.
    task automatic step(input logic c, input logic [1:0] a, input logic r, input logic s,
                        input logic [7:0] d, output logic [7:0] dout);
        cs = c; addr = a; rwb = r; strobe = s; data_in = d;
        @(negedge clk);
        dout = data_out;
        @(posedge clk);
        model_edge(c, a, r, s, d);
        #1;
        chk("txd_model", txd, m_txd());
        chk("busy_model", tx_busy, m_busy());
    endtask

    task automatic idle(input int n);
        logic [7:0] dd;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b1, 1'b0, 8'h00, dd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] dd;
        step(1'b1, a, 1'b0, 1'b1, d, dd);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] dout);
        step(1'b1, a, 1'b1, 1'b1, 8'h00, dout);
    endtask

    initial begin
        logic [7:0] dv;
        logic [9:0] fr;
        int         k;

        reset = 1'b1; cs = 1'b0; addr = 2'd0; rwb = 1'b1; strobe = 1'b0; data_in = 8'h00;
        model_reset();
        #23 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].a, vecs[i].r, 1'b1, vecs[i].d, dv);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d", i), dv, vecs[i].exp);
        end

        // Single 0x41 frame with explicit bit timing.
        fr = {1'b1, 8'h41, 1'b0};
        wr(2'd0, 8'h41);
        chk("a_pre_txd", txd, 1'b1);
        chk("a_pre_busy", tx_busy, 1'b1);
        for (int i = 0; i < 40; i++) begin
            idle(1);
            chk($sformatf("a_bit%0d", i / 4), txd, fr[i / 4]);
            chk("a_busy", tx_busy, 1'b1);
        end
        idle(1);
        chk("a_end_busy", tx_busy, 1'b0);
        chk("a_end_txd", txd, 1'b1);

        // Five back-to-back writes fit and stream without a gap.
        for (int i = 1; i <= 5; i++) wr(2'd0, 8'(i));
        k = 0;
        while (k < 400) begin
            idle(1);
            k++;
            if (!tx_busy) break;
        end
        chk("burst5_len", 8'(k), 8'(197));
        rd(2'd1, dv);
        chk("burst5_status", dv, 8'h30);

        // Sixth consecutive write overflows; OVR clears on the first status read.
        for (int i = 0; i < 6; i++) wr(2'd0, 8'(8'h10 + i));
        rd(2'd1, dv);
        chk("ovr_status1", dv, 8'h04);
        rd(2'd1, dv);
        chk("ovr_status2", dv, 8'h00);
        idle(220);
        chk("ovr_drained", tx_busy, 1'b0);

        // Programmed reset aborts a frame mid-byte.
        wr(2'd0, 8'h5A);
        idle(15);
        chk("prst_pre_txd", txd, 1'b0);
        wr(2'd1, 8'h00);
        chk("prst_txd", txd, 1'b1);
        chk("prst_busy", tx_busy, 1'b0);
        rd(2'd1, dv);
        chk("prst_status", dv, 8'h30);
        rd(2'd2, dv);
        chk("prst_cmd", dv, 8'hA5);

        // Async reset mid-frame returns txd high without a clock.
        wr(2'd0, 8'hC3);
        idle(2);
        chk("arst_pre_txd", txd, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_txd", txd, 1'b1);
        chk("arst_busy", tx_busy, 1'b0);
        cs = 1'b0; strobe = 1'b0;
        model_reset();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        rd(2'd1, dv);
        chk("arst_status", dv, 8'h30);
        rd(2'd2, dv);
        chk("arst_cmd", dv, 8'h00);

        // Random bus traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int         r;
            logic       c;
            logic [1:0] a;
            logic [7:0] exp;
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                idle(1);
            end else if (r < 75) begin
                wr(2'd0, 8'($urandom));
            end else if (r < 87) begin
                exp = m_read(1'b1, 2'd1);
                rd(2'd1, dv);
                chk("rnd_status", dv, exp);
            end else if (r < 89) begin
                wr(2'd1, 8'($urandom));
            end else if (r < 94) begin
                wr(2'(2 + $urandom_range(0, 1)), 8'($urandom));
            end else begin
                c   = 1'($urandom);
                a   = 2'($urandom);
                exp = m_read(c, a);
                step(c, a, 1'b1, 1'b1, 8'h00, dv);
                chk("rnd_read", dv, exp);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acia_tx.md
Name: acia_tx

Overview:
6551-style ACIA transmit slave for the 65C02 system bus, decoded at 0x8000–0x8003.
- Accepts CPU writes to the TX data register into a small FIFO, then serialises them on txd as 8N1 frames.
- Returns status (TDRE etc.) on reads, replacing the behavioural ACIA model used in simulation.
- Sits directly downstream of the CPU bus decode in top; txd drives the board UART pin.

Parameters:
BAUD_DIV, 87, clk cycles per serial bit (10 MHz / 87 ≈ 115200 baud); legal range 2..65535
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  chip select, high when {address[15:2],2'b00} == 16'h8000
addr  in  2  register offset, address[1:0]
rwb  in  1  1 = read, 0 = write (CPU convention)
strobe  in  1  single-cycle commit pulse, one per bus cycle (phi2 falling-edge qualifier from top)
data_in  in  8  CPU write data
data_out  out  8  read data, combinational from addr; 8'h00 when cs low
txd  out  1  serial output, idle high
tx_busy  out  1  high while FIFO non-empty or a frame is in progress

Behaviour:
- Register map, write = cs & strobe & !rwb; read side effects use cs & strobe & rwb:
  - off 0 W: push data_in into FIFO.
  - off 0 R: 8'h00 (no receiver).
  - off 1 R: status. Bit4 TDRE = FIFO not full; bit5 IDLE = !tx_busy; bit2 OVR = sticky overflow; other bits 0.
  - off 1 W: programmed reset (data ignored). Flushes FIFO, clears OVR, aborts any frame (txd=1, FSM IDLE on next edge). Command/control registers keep their values.
  - off 2 / off 3: command / control registers, plain 8-bit R/W storage, no functional effect.
- Reset values: data_out=8'h00 (cs low); txd=1; tx_busy=0; FIFO empty; OVR=0; command=8'h00; control=8'h00; FSM IDLE; baud counter 0.
- FIFO:
  - Push when full and no pop in the same cycle: data dropped, OVR set.
  - Push and pop in the same cycle when full: push accepted, no OVR.
  - OVR clears on a status read strobe. A status read and an overflow in the same cycle leave OVR set.
  - Pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full/empty come from the wrap bit.
- Serial FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, bit count 0, baud counter 0, go to START.
  - START: txd=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each.
  - STOP: txd=1 for BAUD_DIV cycles. Then pop and go to START if FIFO non-empty, else IDLE.
  - Frame = 10*BAUD_DIV cycles. Back-to-back frames have no idle gap.
- Latency: write strobe at edge N → FIFO non-empty after N → pop and START at edge N+1 → txd falls after edge N+1. tx_busy rises after edge N.
- txd is registered, so no glitches.
- The baud counter runs only outside IDLE and reloads at every bit boundary.
- Async reset at any point, including mid-frame: all state goes to reset values immediately; txd returns high without waiting for a clock.

Decomposition:
- Package acia_pkg: register offset constants (ACIA_DATA=2'd0, ACIA_STATUS=2'd1, ACIA_CMD=2'd2, ACIA_CTRL=2'd3), status bit indices (ST_OVR=2, ST_TDRE=4, ST_IDLE=5), ACIA_BASE=16'h8000, FSM state enum.
- One sub-module, acia_tx_fifo: synchronous FIFO with push/pop/full/empty, parameterised by width and depth.
- Shifter, baud counter and register file stay in acia_tx.

Test Plan:
- Reset, then read off 1 → data_out=8'h30 (TDRE=1, IDLE=1); txd=1; tx_busy=0.
- BAUD_DIV=4: write 8'h41 to off 0 → txd low from edge N+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high; tx_busy low 40 cycles after start.
- Write 5 bytes 8'h01..8'h05 back-to-back, FIFO_DEPTH=4 → bytes 1–5 transmitted contiguously with no idle gap and no OVR. Byte 1 is popped on the cycle after its write, so all five fit.
- Write 6 bytes in 6 consecutive cycles → 6th dropped, status reads 8'h04 (TDRE=0, OVR=1). A second status read shows OVR=0.
- Mid-frame write to off 1 → txd=1 next cycle, FIFO empty, status=8'h30. Separately, mid-frame async reset → txd=1 immediately.
- Write 8'hA5 to off 2 and 8'h3C to off 3, read back → 8'hA5 / 8'h3C. Programmed reset leaves both unchanged. Read with cs=0 → 8'h00.
